// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit slice.
package lsu_pkg;

    localparam int ISA_WIDTH = 32;

    // Access size codes carried on req_size (3 behaves as word).
    localparam logic [1:0] LSU_B = 2'd0;
    localparam logic [1:0] LSU_H = 2'd1;
    localparam logic [1:0] LSU_W = 2'd2;

    // Request context kept across REQ/WAIT for load extraction.
    typedef struct packed {
        logic [1:0] addr_lo;
        logic [1:0] size;
        logic       uns;
    } lsu_ctx_t;

endpackage

// File: rtl/lsu_if.sv
// Execute-side request/response and memory-side bus of the load/store unit.
// slave  : the view taken by lsu itself.
// master : the view taken by its environment (execute stage plus memory).
interface lsu_if
    import lsu_pkg::*;
();

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [ISA_WIDTH-1:0] req_addr;
    logic [ISA_WIDTH-1:0] req_wdata;
    logic [1:0]           req_size;
    logic                 req_unsigned;

    logic                 resp_valid;
    logic [ISA_WIDTH-1:0] resp_rdata;
    logic                 resp_err;

    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_we;
    logic [ISA_WIDTH-1:0] mem_addr;
    logic [ISA_WIDTH-1:0] mem_wdata;
    logic [3:0]           mem_wstrb;
    logic                 mem_resp_valid;
    logic [ISA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store replication, strobes, load shift and
// extension, and misalignment detection. Kept free of state so a cache can
// reuse it.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]           addr_lo,
    input  logic [1:0]           size,
    input  logic                 uns,
    input  logic [ISA_WIDTH-1:0] wdata,
    input  logic [ISA_WIDTH-1:0] rdata,
    output logic [ISA_WIDTH-1:0] wdata_rep,
    output logic [3:0]           wstrb,
    output logic [ISA_WIDTH-1:0] rdata_ext,
    output logic                 misaligned
);

    logic        [ISA_WIDTH-1:0] shifted;
    logic signed [ISA_WIDTH-1:0] byte_sx;
    logic signed [ISA_WIDTH-1:0] half_sx;

    assign shifted = rdata >> {addr_lo, 3'b000};
    assign byte_sx = {{(ISA_WIDTH-8){shifted[7]}}, shifted[7:0]};
    assign half_sx = {{(ISA_WIDTH-16){shifted[15]}}, shifted[15:0]};

    // Per-size lane formatting; word (and the unused code 3) is the default.
    always_comb begin
        wdata_rep  = wdata;
        wstrb      = 4'b1111;
        rdata_ext  = shifted;
        misaligned = (addr_lo != 2'b00);
        case (size)
            LSU_B: begin
                wdata_rep  = {(ISA_WIDTH/8){wdata[7:0]}};
                wstrb      = 4'b0001 << addr_lo;
                rdata_ext  = uns ? {{(ISA_WIDTH-8){1'b0}}, shifted[7:0]} : byte_sx;
                misaligned = 1'b0;
            end
            LSU_H: begin
                wdata_rep  = {(ISA_WIDTH/16){wdata[15:0]}};
                wstrb      = 4'b0011 << addr_lo;
                rdata_ext  = uns ? {{(ISA_WIDTH-16){1'b0}}, shifted[15:0]} : half_sx;
                misaligned = addr_lo[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, converted into a word-aligned,
// byte-strobed memory transaction, answered with a one-cycle response.
module lsu
    import lsu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t               state;
    lsu_ctx_t             ctx;

    logic                 mem_we_q;
    logic [ISA_WIDTH-1:0] mem_addr_q;
    logic [ISA_WIDTH-1:0] mem_wdata_q;
    logic [3:0]           mem_wstrb_q;
    logic                 resp_valid_q;
    logic [ISA_WIDTH-1:0] resp_rdata_q;
    logic                 resp_err_q;

    logic [1:0]           al_addr_lo;
    logic [1:0]           al_size;
    logic [ISA_WIDTH-1:0] al_wdata;
    logic [3:0]           al_wstrb;
    logic [ISA_WIDTH-1:0] al_rdata;
    logic                 al_mis;

    // In IDLE the aligner formats the live request; afterwards it decodes the
    // returning word against the latched context.
    assign al_addr_lo = (state == IDLE) ? bus.req_addr[1:0] : ctx.addr_lo;
    assign al_size    = (state == IDLE) ? bus.req_size      : ctx.size;

    lsu_align u_align (
        .addr_lo    (al_addr_lo),
        .size       (al_size),
        .uns        (ctx.uns),
        .wdata      (bus.req_wdata),
        .rdata      (bus.mem_rdata),
        .wdata_rep  (al_wdata),
        .wstrb      (al_wstrb),
        .rdata_ext  (al_rdata),
        .misaligned (al_mis)
    );

    assign bus.req_ready     = (state == IDLE);
    assign bus.mem_req_valid = (state == REQ);
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_wstrb     = mem_wstrb_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_err      = resp_err_q;

    // Request sequencing with registered memory-side and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ctx          <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        ctx.addr_lo <= bus.req_addr[1:0];
                        ctx.size    <= bus.req_size;
                        ctx.uns     <= bus.req_unsigned;
                        if (al_mis) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state        <= RESP;
                        end else begin
                            mem_we_q    <= bus.req_we;
                            mem_addr_q  <= {bus.req_addr[ISA_WIDTH-1:2], 2'b00};
                            mem_wdata_q <= al_wdata;
                            mem_wstrb_q <= bus.req_we ? al_wstrb : 4'b0000;
                            state       <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= mem_we_q ? '0 : al_rdata;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: acts as execute stage and memory.
module tb_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    lsu_if bus ();

    lsu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    int          obs_resp_cyc;
    int          obs_pulses;
    logic        obs_memreq;
    logic        obs_stable;
    logic        obs_rdy_low;
    logic        obs_err;
    logic [31:0] obs_rdata;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_wstrb;
    logic        obs_we;

    task automatic idle_inputs();
        bus.req_valid      = 1'b0;
        bus.req_we         = 1'b0;
        bus.req_addr       = 32'h0;
        bus.req_wdata      = 32'h0;
        bus.req_size       = LSU_W;
        bus.req_unsigned   = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'h0;
    endtask

    // Issues one request at posedge+1 and plays memory with the given delays,
    // recording what the unit did over ncyc cycles after the accept edge.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic uns, input logic [31:0] rdata,
                              input int req_dly, input int resp_dly, input int ncyc);
        int rq_cnt;
        int rs_cnt;
        bit hs_done;
        bit resp_sent;
        rq_cnt = 0; rs_cnt = 0; hs_done = 0; resp_sent = 0;
        obs_resp_cyc = -1; obs_pulses = 0; obs_memreq = 1'b0; obs_stable = 1'b1;
        obs_rdy_low = 1'b1; obs_err = 1'bx; obs_rdata = 'x;
        obs_addr = 'x; obs_wdata = 'x; obs_wstrb = 'x; obs_we = 1'bx;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            if (bus.mem_req_ready) hs_done = 1;
            bus.req_valid      = 1'b0;
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            if (bus.req_ready && obs_resp_cyc < 0) obs_rdy_low = 1'b0;
            if (bus.resp_valid) begin
                obs_pulses++;
                if (obs_resp_cyc < 0) begin
                    obs_resp_cyc = c;
                    obs_rdata    = bus.resp_rdata;
                    obs_err      = bus.resp_err;
                end
            end
            if (bus.mem_req_valid) begin
                if (!obs_memreq) begin
                    obs_memreq = 1'b1;
                    obs_addr   = bus.mem_addr;
                    obs_wdata  = bus.mem_wdata;
                    obs_wstrb  = bus.mem_wstrb;
                    obs_we     = bus.mem_we;
                end else if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.mem_we} !==
                             {obs_addr, obs_wdata, obs_wstrb, obs_we}) begin
                    obs_stable = 1'b0;
                end
                if (rq_cnt >= req_dly) bus.mem_req_ready = 1'b1;
                rq_cnt++;
            end else if (hs_done && !resp_sent) begin
                if (rs_cnt >= resp_dly) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_rdata      = rdata;
                    resp_sent          = 1;
                end
                rs_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_mis++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if ({bus.resp_valid, bus.resp_err, bus.mem_req_valid, bus.mem_we} !== 4'b0000) begin n_mis++; $display("FAIL reset_flags: got %b want 0000", {bus.resp_valid, bus.resp_err, bus.mem_req_valid, bus.mem_we}); end
        n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_mis++; $display("FAIL reset_resp_rdata: got %h want 0", bus.resp_rdata); end
        n_cmp++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 68'h0) begin n_mis++; $display("FAIL reset_mem_bus: got %h/%h/%b want 0", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb); end
    endtask

    task automatic test_load_half();
        run_access(1'b0, 32'h8000_0002, 32'h0, LSU_H, 1'b0, 32'h8001_1234, 0, 0, 6);
        n_cmp++; if (obs_resp_cyc !== 3) begin n_mis++; $display("FAIL lh_latency: got %0d want 3", obs_resp_cyc); end
        n_cmp++; if (obs_rdata !== 32'hFFFF_8001) begin n_mis++; $display("FAIL lh_rdata: got %h want ffff8001", obs_rdata); end
        n_cmp++; if ({obs_addr, obs_wstrb, obs_we} !== {32'h8000_0000, 4'b0000, 1'b0}) begin n_mis++; $display("FAIL lh_mem: got %h/%b/%b want 80000000/0000/0", obs_addr, obs_wstrb, obs_we); end
        run_access(1'b0, 32'h8000_0002, 32'h0, LSU_H, 1'b1, 32'h8001_1234, 0, 0, 6);
        n_cmp++; if (obs_rdata !== 32'h0000_8001) begin n_mis++; $display("FAIL lhu_rdata: got %h want 00008001", obs_rdata); end
        run_access(1'b0, 32'h8000_0000, 32'h0, LSU_H, 1'b0, 32'h8001_1234, 0, 0, 6);
        n_cmp++; if (obs_rdata !== 32'h0000_1234) begin n_mis++; $display("FAIL lh_low_rdata: got %h want 00001234", obs_rdata); end
        run_access(1'b0, 32'h8000_0003, 32'h0, LSU_B, 1'b0, 32'h8001_1234, 0, 0, 6);
        n_cmp++; if (obs_rdata !== 32'hFFFF_FF80) begin n_mis++; $display("FAIL lb_rdata: got %h want ffffff80", obs_rdata); end
        run_access(1'b0, 32'h8000_0000, 32'h0, 2'd3, 1'b1, 32'h8001_1234, 0, 0, 6);
        n_cmp++; if (obs_rdata !== 32'h8001_1234) begin n_mis++; $display("FAIL lw_size3_rdata: got %h want 80011234", obs_rdata); end
        run_access(1'b0, 32'h8000_0003, 32'h0, LSU_B, 1'b1, 32'h8001_1234, 0, 0, 6);
        n_cmp++; if (obs_rdata !== 32'h0000_0080) begin n_mis++; $display("FAIL lbu_rdata: got %h want 00000080", obs_rdata); end
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 32'h8000_0002, 32'h0, LSU_W, 1'b0, 32'h1111_1111, 0, 0, 6);
        n_cmp++; if (obs_resp_cyc !== 1) begin n_mis++; $display("FAIL lw_mis_latency: got %0d want 1", obs_resp_cyc); end
        n_cmp++; if ({obs_err, obs_memreq, obs_pulses[3:0]} !== {1'b1, 1'b0, 4'd1}) begin n_mis++; $display("FAIL lw_mis_err_memreq_pulses: got %b/%b/%0d want 1/0/1", obs_err, obs_memreq, obs_pulses); end
        n_cmp++; if (obs_rdata !== 32'h0) begin n_mis++; $display("FAIL lw_mis_rdata: got %h want 0", obs_rdata); end
        run_access(1'b1, 32'h8000_0001, 32'h0000_5555, LSU_H, 1'b0, 32'h0, 0, 0, 6);
        n_cmp++; if ({obs_resp_cyc[3:0], obs_err, obs_memreq} !== {4'd1, 1'b1, 1'b0}) begin n_mis++; $display("FAIL sh_mis: got cyc %0d err %b memreq %b want 1/1/0", obs_resp_cyc, obs_err, obs_memreq); end
    endtask

    task automatic test_store_word();
        run_access(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, LSU_W, 1'b0, 32'h7777_7777, 0, 0, 6);
        n_cmp++; if (obs_resp_cyc !== 3) begin n_mis++; $display("FAIL sw_latency: got %0d want 3", obs_resp_cyc); end
        n_cmp++; if ({obs_addr, obs_wdata, obs_wstrb, obs_we} !== {32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 1'b1}) begin n_mis++; $display("FAIL sw_mem: got %h/%h/%b/%b want 80000004/deadbeef/1111/1", obs_addr, obs_wdata, obs_wstrb, obs_we); end
        n_cmp++; if ({obs_err, obs_rdata} !== 33'h0) begin n_mis++; $display("FAIL sw_resp: got err %b rdata %h want 0/0", obs_err, obs_rdata); end
    endtask

    task automatic test_store_byte();
        run_access(1'b1, 32'h8000_0003, 32'h0000_00A5, LSU_B, 1'b0, 32'h0, 0, 0, 6);
        n_cmp++; if ({obs_addr, obs_wdata, obs_wstrb} !== {32'h8000_0000, 32'hA5A5_A5A5, 4'b1000}) begin n_mis++; $display("FAIL sb_mem: got %h/%h/%b want 80000000/a5a5a5a5/1000", obs_addr, obs_wdata, obs_wstrb); end
        run_access(1'b1, 32'h8000_0002, 32'h0000_BEEF, LSU_H, 1'b0, 32'h0, 0, 0, 6);
        n_cmp++; if ({obs_wdata, obs_wstrb} !== {32'hBEEF_BEEF, 4'b1100}) begin n_mis++; $display("FAIL sh_mem: got %h/%b want beefbeef/1100", obs_wdata, obs_wstrb); end
    endtask

    task automatic test_back_pressure();
        run_access(1'b0, 32'h8000_0008, 32'h0, LSU_W, 1'b0, 32'h1234_5678, 3, 4, 14);
        n_cmp++; if (obs_resp_cyc !== 10) begin n_mis++; $display("FAIL bp_latency: got %0d want 10", obs_resp_cyc); end
        n_cmp++; if ({obs_stable, obs_rdy_low, obs_addr} !== {1'b1, 1'b1, 32'h8000_0008}) begin n_mis++; $display("FAIL bp_stable_ready_addr: got %b/%b/%h want 1/1/80000008", obs_stable, obs_rdy_low, obs_addr); end
        n_cmp++; if (obs_pulses !== 1) begin n_mis++; $display("FAIL bp_pulses: got %0d want 1", obs_pulses); end
        n_cmp++; if (obs_rdata !== 32'h1234_5678) begin n_mis++; $display("FAIL bp_rdata: got %h want 12345678", obs_rdata); end
    endtask

    task automatic test_reset_in_wait();
        int pulses;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h8000_0010;
        bus.req_wdata = 32'hCAFE_F00D; bus.req_size = LSU_W; bus.req_unsigned = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.mem_req_valid !== 1'b1) begin n_mis++; $display("FAIL rw_in_req: got %b want 1", bus.mem_req_valid); end
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        n_cmp++; if ({bus.mem_req_valid, bus.req_ready, bus.mem_wstrb, bus.resp_rdata} !== {1'b0, 1'b0, 4'b1111, 32'h1234_5678}) begin n_mis++; $display("FAIL rw_in_wait: got %b/%b/%b/%h want 0/0/1111/12345678", bus.mem_req_valid, bus.req_ready, bus.mem_wstrb, bus.resp_rdata); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({bus.req_ready, bus.mem_req_valid, bus.resp_valid, bus.resp_err, bus.mem_we} !== 5'b10000) begin n_mis++; $display("FAIL rw_async_flags: got %b want 10000", {bus.req_ready, bus.mem_req_valid, bus.resp_valid, bus.resp_err, bus.mem_we}); end
        n_cmp++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.resp_rdata} !== 100'h0) begin n_mis++; $display("FAIL rw_async_data: got %h/%h/%b/%h want 0", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.resp_rdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hFFFF_FFFF;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            bus.mem_resp_valid = 1'b0;
            if (bus.resp_valid) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_mis++; $display("FAIL rw_stale_resp: got %0d pulses want 0", pulses); end
        run_access(1'b0, 32'h8000_0001, 32'h0, LSU_B, 1'b0, 32'h0000_FF00, 0, 0, 6);
        n_cmp++; if ({obs_resp_cyc[3:0], obs_rdata} !== {4'd3, 32'hFFFF_FFFF}) begin n_mis++; $display("FAIL rw_lb_after: got cyc %0d rdata %h want 3/ffffffff", obs_resp_cyc, obs_rdata); end
    endtask

    initial begin
        test_reset();
        test_load_half();
        test_misaligned();
        test_store_word();
        test_store_byte();
        test_back_pressure();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the execute stage in the NPC core. It takes one memory request at a time: address, store data, size and signedness. It converts the request into a word-aligned, byte-strobed transaction on a valid/ready memory port, then returns aligned and extended load data (or a store acknowledgement) as a one-cycle response. While a request is in flight it back-pressures the execute stage.

## Interface
- `ISA_WIDTH`, 32 (from config.v): data and address width.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  1  execute stage presents a request; held stable until accepted.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid & req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ISA_WIDTH  byte address.
- `req_wdata`  in  ISA_WIDTH  store data; the low byte or half is significant for sub-word stores.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_unsigned`  in  1  loads only: zero-extend instead of sign-extend.
- `resp_valid`  out  1  one-cycle pulse on completion.
- `resp_rdata`  out  ISA_WIDTH  extended load data; 0 for stores and errors; held until the next response.
- `resp_err`  out  1  misaligned access; valid with `resp_valid`.
- `mem_req_valid`  out  1  memory request.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_we`  out  1  write.
- `mem_addr`  out  ISA_WIDTH  `req_addr` with bits [1:0] cleared.
- `mem_wdata`  out  ISA_WIDTH  replicated store data.
- `mem_wstrb`  out  4  byte strobes; 0 for loads.
- `mem_resp_valid`  in  1  memory completion; applies to both loads and stores.
- `mem_rdata`  in  ISA_WIDTH  read word, valid with `mem_resp_valid`.

## Operation
States are IDLE, REQ, WAIT and RESP.

- **IDLE**
  - `req_ready=1`.
  - On accept, latch `we`, `addr`, `wdata`, `size` and `unsigned`.
  - If the access is misaligned, go to RESP with the error flag set. Misaligned means half with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - Otherwise go to REQ.
- **REQ**
  - `mem_req_valid=1`, with `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` driven from latched values and stable.
  - On `mem_req_ready`, go to WAIT.
- **WAIT**
  - On `mem_resp_valid`, register the extracted data (loads only) and go to RESP.
- **RESP**
  - `resp_valid=1` for exactly one cycle, then IDLE.
- `mem_resp_valid` is ignored outside WAIT. The memory must not respond in the same cycle it asserts `mem_req_ready`.
- Store formatting:
  - byte: `mem_wdata={4{wdata[7:0]}}`, `mem_wstrb=4'b0001<<addr[1:0]`.
  - half: `mem_wdata={2{wdata[15:0]}}`, `mem_wstrb=4'b0011<<addr[1:0]`.
  - word: `mem_wdata=wdata`, `mem_wstrb=4'b1111`.
- Load extraction: `shifted = mem_rdata >> (8*addr[1:0])`. Then:
  - byte and half: sign-extend bit 7 / 15, or zero-extend if `unsigned`.
  - word: pass through.
- Reset values:
  - state = IDLE.
  - `req_ready=1` (combinational from IDLE).
  - `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `mem_req_valid=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `mem_wstrb=0`.

## Timing
- `req_ready` and `mem_req_valid` are Moore outputs decoded from the state. `resp_rdata` and `resp_err` are registers.
- Minimum latency for an aligned access, counting the accept edge as cycle 0:
  - cycle 0: accept.
  - cycle 1: REQ with `mem_req_ready=1`.
  - cycle 2: WAIT with `mem_resp_valid=1`.
  - cycle 3: `resp_valid` is high.
- Misaligned access: `resp_valid` and `resp_err` are high in cycle 1, and no memory transaction occurs.
- Back-to-back requests: a new accept is possible in the cycle after RESP, so throughput is at most one access per 4 cycles.
- Stalls: arbitrary `mem_req_ready` or `mem_resp_valid` delays extend REQ or WAIT indefinitely. No timeout.
- Reset mid-operation (any state):
  - Immediately return to IDLE with reset output values.
  - A pending memory response arriving later is discarded, because the unit is not in WAIT.

## Structure
- Add size codes to config.v: `` `LSU_B ``=0, `` `LSU_H ``=1, `` `LSU_W ``=2.
- FSM state encodings are local parameters of lsu.
- One combinational sub-module, `lsu_align`, holds the store replication, strobe generation, load shift/extend and misalignment check. It is shared by the store and load paths and reusable by a future cache.
- The FSM and latches stay in lsu.

## Test plan
1. **Store word:** sw `0xDEADBEEF` to `0x80000004`, with `mem_req_ready` and `mem_resp_valid` each asserted on first opportunity → `mem_addr=0x80000004`, `mem_wstrb=4'b1111`, `resp_valid` in cycle 3, `resp_err=0`, `resp_rdata=0`.
2. **Store byte:** sb `0x000000A5` to `0x80000003` → `mem_addr=0x80000000`, `mem_wdata=0xA5A5A5A5`, `mem_wstrb=4'b1000`.
3. **Load half, signed and unsigned:** `mem_rdata=0x80011234`, address `0x80000002`.
   - lh → `resp_rdata=0xFFFF8001`.
   - lhu → `resp_rdata=0x00008001`.
   - Repeat at address `0x80000000`: lh → `0x00001234`.
4. **Misaligned:** lw at `0x80000002` → `resp_valid=1` and `resp_err=1` in cycle 1, `mem_req_valid` never asserted; sh at `0x80000001` gives the same result.
5. **Back-pressure:** hold `mem_req_ready=0` for 3 cycles, then `mem_resp_valid` 5 cycles later → `mem_req_valid` and `mem_addr` stay stable, `req_ready=0` throughout, exactly one `resp_valid` pulse.
6. **Reset in WAIT:** assert `rst` while in WAIT → all outputs return to reset values asynchronously. A `mem_resp_valid` pulse afterwards produces no `resp_valid`. A subsequent lb from `0x80000001` with `mem_rdata=0x0000FF00` returns `0xFFFFFFFF`.
